clk_enable_gen: RTL and testbench

CLK_ENABLE_GEN -- requirements
Module: clk_enable_gen

---
 rtl/clk_enable_gen.sv | 134 +++++++++++++
 tb/tb_clk_enable_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/clk_enable_gen.sv
// Multi-channel phase-accumulator clock-enable generator with an advisory lock indicator.
// Optional common phase reset (phase_sync port) is enabled by defining CLK_ENABLE_GEN_PHASE_ALIGN_EN.
module clk_enable_gen #(
    parameter int                   NUM_CH      = 3,
    parameter int                   ACC_WIDTH   = 24,
    parameter logic [ACC_WIDTH-1:0] INC_DEFAULT = '0,
    parameter int                   LOCK_CYCLES = 256
) (
    input  logic                 refclk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_ch,
    input  logic [ACC_WIDTH-1:0] cfg_inc,
    input  logic [NUM_CH-1:0]    ch_en,
`ifdef CLK_ENABLE_GEN_PHASE_ALIGN_EN
    input  logic                 phase_sync,
`endif
    output logic [NUM_CH-1:0]    ce,
    output logic [NUM_CH-1:0]    outclk,
    output logic                 locked
);

    localparam int               CNT_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic {SETTLE, LOCKED} lock_state_e;

    logic        cfg_valid;
    logic        sync_clr;

    assign cfg_valid = cfg_we && (int'(cfg_ch) < NUM_CH);

`ifdef CLK_ENABLE_GEN_PHASE_ALIGN_EN
    assign sync_clr = phase_sync;
`else
    assign sync_clr = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [ACC_WIDTH:0]   sum;
            logic [ACC_WIDTH-1:0] inc_q, inc_d;
            logic [ACC_WIDTH-1:0] acc_q, acc_d;
            logic                 ce_q, ce_d;
            logic                 oc_q, oc_d;

            // outclk toggles on the same edge that raises ce, so both stay in step.
            always_comb begin
                sum   = {1'b0, acc_q} + {1'b0, inc_q};
                inc_d = inc_q;
                acc_d = acc_q;
                ce_d  = 1'b0;
                oc_d  = oc_q;
                if (cfg_valid && (cfg_ch == 3'(gi))) begin
                    inc_d = cfg_inc;
                end
                if (sync_clr) begin
                    acc_d = '0;
                    oc_d  = 1'b0;
                end else if (ch_en[gi]) begin
                    acc_d = sum[ACC_WIDTH-1:0];
                    ce_d  = sum[ACC_WIDTH];
                    oc_d  = oc_q ^ sum[ACC_WIDTH];
                end
            end

            always_ff @(posedge refclk or negedge rst_n) begin
                if (!rst_n) begin
                    inc_q <= INC_DEFAULT;
                    acc_q <= '0;
                    ce_q  <= 1'b0;
                    oc_q  <= 1'b0;
                end else begin
                    inc_q <= inc_d;
                    acc_q <= acc_d;
                    ce_q  <= ce_d;
                    oc_q  <= oc_d;
                end
            end

            assign ce[gi]     = ce_q;
            assign outclk[gi] = oc_q;
        end
    endgenerate

    lock_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             locked_q, locked_d;

    // Any increment change or phase realignment restarts the settle window.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SETTLE: begin
                if (cfg_valid || sync_clr) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOCKED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOCKED: begin
                if (cfg_valid || sync_clr) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
        endcase
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SETTLE;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

    assign locked = locked_q;

endmodule

// File: tb/tb_clk_enable_gen.sv
// Scoreboard bench for clk_enable_gen: stimulus queues expected ce/outclk/locked per cycle,
// a negedge monitor pops and compares. Phase-align checks run only with the macro defined.
module tb_clk_enable_gen;

    localparam int LOCK = 16;

    logic       refclk;
    logic       rst_n;
    logic       cfg_we;
    logic [2:0] cfg_ch;
    logic [7:0] cfg_inc;
    logic [2:0] ch_en;
    logic       phase_sync;
    logic [2:0] ce;
    logic [2:0] outclk;
    logic       locked;

    clk_enable_gen #(
        .NUM_CH      (3),
        .ACC_WIDTH   (8),
        .INC_DEFAULT (8'h00),
        .LOCK_CYCLES (LOCK)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_inc    (cfg_inc),
        .ch_en      (ch_en),
`ifdef CLK_ENABLE_GEN_PHASE_ALIGN_EN
        .phase_sync (phase_sync),
`endif
        .ce         (ce),
        .outclk     (outclk),
        .locked     (locked)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    int cyc = 0;
    always @(posedge refclk) cyc <= cyc + 1;

    int         due_q[$];
    logic [6:0] exp_q[$];
    string      name_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    int since_wr = 0;
    int n_en[3];
    int inc_m[3];

    // Closed-form accumulator behaviour after n enabled edges from acc=0.
    function automatic logic carry_f(input int n, input int inc);
        return ((n * inc) / 256) != (((n - 1) * inc) / 256);
    endfunction

    function automatic logic oc_f(input int n, input int inc);
        return (((n * inc) / 256) % 2) == 1;
    endfunction

    task automatic push(input int due, input logic [2:0] ece, input logic [2:0] eoc,
                        input logic elk, input string name);
        due_q.push_back(due);
        exp_q.push_back({ece, eoc, elk});
        name_q.push_back(name);
    endtask

    always @(negedge refclk) begin
        while (due_q.size() > 0 && due_q[0] <= cyc) begin
            int         d;
            logic [6:0] e;
            string      nm;
            d  = due_q.pop_front();
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if (d != cyc || ce !== e[6:4] || outclk !== e[3:1] || locked !== e[0]) begin
                n_bad++;
                $display("FAIL %s cyc=%0d: got ce=%b outclk=%b locked=%b, expected ce=%b outclk=%b locked=%b",
                         nm, cyc, ce, outclk, locked, e[6:4], e[3:1], e[0]);
            end else begin
                $display("chk %s cyc=%0d ce=%b outclk=%b locked=%b", nm, cyc, ce, outclk, locked);
            end
        end
    end

    task automatic step(input bit rst_val, input logic [2:0] en, input logic we,
                        input logic [2:0] ch, input logic [7:0] inc,
                        input logic [2:0] ece, input logic [2:0] eoc,
                        input bit chk, input string name);
        @(negedge refclk);
        rst_n   = rst_val;
        ch_en   = en;
        cfg_we  = we;
        cfg_ch  = ch;
        cfg_inc = inc;
        if (!rst_val || phase_sync || (we && ch < 3)) since_wr = 0;
        else since_wr++;
        if (chk) push(cyc + 1, ece, eoc, since_wr >= LOCK, name);
    endtask

    task automatic run(input logic [2:0] en, input int cycles, input string name, input bit chk);
        for (int k = 0; k < cycles; k++) begin
            logic [2:0] ece;
            logic [2:0] eoc;
            for (int i = 0; i < 3; i++) begin
                if (en[i]) n_en[i]++;
                ece[i] = en[i] ? carry_f(n_en[i], inc_m[i]) : 1'b0;
                eoc[i] = oc_f(n_en[i], inc_m[i]);
            end
            step(1'b1, en, 1'b0, 3'd0, 8'd0, ece, eoc, chk, name);
        end
    endtask

    // Writes are only issued while the target accumulator sits at zero phase.
    task automatic wr(input logic [2:0] ch, input logic [7:0] val, input string name);
        logic [2:0] eoc;
        for (int i = 0; i < 3; i++) eoc[i] = oc_f(n_en[i], inc_m[i]);
        step(1'b1, 3'b000, 1'b1, ch, val, 3'b000, eoc, 1'b1, name);
        if (ch < 3) begin
            inc_m[ch] = int'(val);
            n_en[ch]  = 0;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_we     = 1'b0;
        cfg_ch     = 3'd0;
        cfg_inc    = 8'd0;
        ch_en      = 3'b000;
        phase_sync = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_en[i]  = 0;
            inc_m[i] = 0;
        end

        step(1'b0, 3'b000, 1'b0, 3'd0, 8'd0, 3'b000, 3'b000, 1'b1, "reset");
        step(1'b0, 3'b000, 1'b0, 3'd0, 8'd0, 3'b000, 3'b000, 1'b1, "reset");
        run(3'b000, 20, "lock_rise", 1'b1);

        wr(3'd0, 8'd64, "wr_inc0");
        wr(3'd1, 8'd128, "wr_inc1");
        wr(3'd2, 8'd0, "wr_inc2");
        run(3'b111, 18, "run_all", 1'b1);
        run(3'b110, 5, "ch0_hold", 1'b1);
        run(3'b111, 8, "ch0_resume", 1'b1);

        wr(3'd5, 8'h10, "wr_bad_ch");
        run(3'b000, 2, "idle", 1'b1);
        wr(3'd2, 8'd255, "wr_inc2_max");
        run(3'b000, 17, "relock", 1'b1);
        run(3'b100, 9, "ch2_max", 1'b1);

        run(3'b011, 5, "pre_reset", 1'b1);
        run(3'b011, 1, "pre_reset", 1'b0);
        @(posedge refclk);
        #2;
        rst_n = 1'b0;
        push(cyc, 3'b000, 3'b000, 1'b0, "rst_async");
        for (int i = 0; i < 3; i++) begin
            n_en[i]  = 0;
            inc_m[i] = 0;
        end
        step(1'b0, 3'b111, 1'b0, 3'd0, 8'd0, 3'b000, 3'b000, 1'b1, "rst_hold");
        run(3'b111, 18, "post_rst", 1'b1);

`ifdef CLK_ENABLE_GEN_PHASE_ALIGN_EN
        wr(3'd0, 8'd64, "pa_wr0");
        wr(3'd1, 8'd32, "pa_wr1");
        run(3'b011, 3, "pa_pre", 1'b1);
        phase_sync = 1'b1;
        step(1'b1, 3'b011, 1'b0, 3'd0, 8'd0, 3'b000, 3'b000, 1'b1, "pa_sync");
        n_en[0] = 0;
        n_en[1] = 0;
        @(negedge refclk);
        phase_sync = 1'b0;
        n_en[0] = 1;
        n_en[1] = 1;
        since_wr = 1;
        ch_en    = 3'b011;
        push(cyc + 1, 3'b000, {1'b0, 2'b00}, 1'b0, "pa_post");
        run(3'b011, 7, "pa_run", 1'b1);
`endif

        for (int t = 0; t < 10 && due_q.size() > 0; t++) @(posedge refclk);
        if (due_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", due_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
